// File: rtl/fib_stream_checker.sv
// Fibonacci stream checker: verifies each sampled term is the sum of the
// previous two (mod 2^DATA_WIDTH), logging the first mismatch and first wrap.
module fib_stream_checker #(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_TERMS   = 64,
    parameter bit STRICT_SEED = 1'b1,
    parameter int CNT_W       = $clog2(MAX_TERMS + 1)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_en,
    input  logic                  clear,
    output logic                  busy,
    output logic [CNT_W-1:0]      term_count,
    output logic                  done,
    output logic                  err,
    output logic [CNT_W-1:0]      err_index,
    output logic [DATA_WIDTH-1:0] err_expected,
    output logic [DATA_WIDTH-1:0] err_actual,
    output logic                  ovf,
    output logic [CNT_W-1:0]      ovf_index
);

    typedef enum logic [2:0] {
        S_SEED0,
        S_SEED1,
        S_CHECK,
        S_ERROR,
        S_DONE
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1);
    localparam logic [CNT_W-1:0]      MAX_CNT = CNT_W'(MAX_TERMS);

    state_t                state_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] prev2_q;
    logic                  busy_q;
    logic [CNT_W-1:0]      term_count_q;
    logic                  done_q;
    logic                  err_q;
    logic [CNT_W-1:0]      err_index_q;
    logic [DATA_WIDTH-1:0] err_expected_q;
    logic [DATA_WIDTH-1:0] err_actual_q;
    logic                  ovf_q;
    logic [CNT_W-1:0]      ovf_index_q;

    logic [DATA_WIDTH:0]   sum_d;
    logic [DATA_WIDTH-1:0] expected_d;
    logic                  mismatch_d;
    logic                  accept_d;
    logic [CNT_W-1:0]      count_d;

    // Expected term for the current state and whether the sample matches it
    always_comb begin
        sum_d      = {1'b0, prev_q} + {1'b0, prev2_q};
        expected_d = '0;
        mismatch_d = 1'b0;
        accept_d   = in_en && !clear &&
                     (state_q inside {S_SEED0, S_SEED1, S_CHECK});
        count_d    = term_count_q + 1'b1;
        unique case (state_q)
            S_SEED0, S_SEED1: begin
                expected_d = ONE;
                mismatch_d = STRICT_SEED && (in_data != ONE);
            end
            S_CHECK: begin
                expected_d = sum_d[DATA_WIDTH-1:0];
                mismatch_d = (in_data != expected_d);
            end
            default: begin
                expected_d = '0;
                mismatch_d = 1'b0;
            end
        endcase
    end

    // Checker FSM with all outputs held in registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_SEED0;
            prev_q         <= '0;
            prev2_q        <= '0;
            busy_q         <= 1'b0;
            term_count_q   <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            err_index_q    <= '0;
            err_expected_q <= '0;
            err_actual_q   <= '0;
            ovf_q          <= 1'b0;
            ovf_index_q    <= '0;
        end else if (clear) begin
            state_q        <= S_SEED0;
            prev_q         <= '0;
            prev2_q        <= '0;
            busy_q         <= 1'b0;
            term_count_q   <= '0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            err_index_q    <= '0;
            err_expected_q <= '0;
            err_actual_q   <= '0;
            ovf_q          <= 1'b0;
            ovf_index_q    <= '0;
        end else begin
            done_q <= 1'b0;
            busy_q <= !(state_q inside {S_ERROR, S_DONE});
            if (accept_d) begin
                term_count_q <= count_d;
                prev_q       <= in_data;
                if (state_q != S_SEED0) begin
                    prev2_q <= prev_q;
                end
                if (mismatch_d) begin
                    state_q        <= S_ERROR;
                    busy_q         <= 1'b0;
                    err_q          <= 1'b1;
                    err_index_q    <= term_count_q;
                    err_expected_q <= expected_d;
                    err_actual_q   <= in_data;
                end else begin
                    if (state_q == S_CHECK && sum_d[DATA_WIDTH] && !ovf_q) begin
                        ovf_q       <= 1'b1;
                        ovf_index_q <= term_count_q;
                    end
                    if (count_d == MAX_CNT) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        unique case (state_q)
                            S_SEED0: state_q <= S_SEED1;
                            S_SEED1: state_q <= S_CHECK;
                            default: state_q <= state_q;
                        endcase
                    end
                end
            end
        end
    end

    assign busy         = busy_q;
    assign term_count   = term_count_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_index    = err_index_q;
    assign err_expected = err_expected_q;
    assign err_actual   = err_actual_q;
    assign ovf          = ovf_q;
    assign ovf_index    = ovf_index_q;

endmodule

// File: tb/tb_fib_stream_checker.sv
// Bench for fib_stream_checker: directed and randomized streams checked
// against a history-based reference model.
module tb_fib_stream_checker;

    localparam int DW = 8;
    localparam int MT = 20;
    localparam int CW = $clog2(MT + 1);

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          in_en  = 1'b0;
    logic          clear  = 1'b0;
    logic [DW-1:0] in_data = '0;

    logic          busy, done, err, ovf;
    logic [CW-1:0] term_count, err_index, ovf_index;
    logic [DW-1:0] err_expected, err_actual;

    logic          ns_busy, ns_done, ns_err, ns_ovf;
    logic [CW-1:0] ns_term_count, ns_err_index, ns_ovf_index;
    logic [DW-1:0] ns_err_expected, ns_err_actual;

    fib_stream_checker #(
        .DATA_WIDTH(DW), .MAX_TERMS(MT), .STRICT_SEED(1'b1)
    ) u_dut (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_en(in_en),
        .clear(clear), .busy(busy), .term_count(term_count), .done(done),
        .err(err), .err_index(err_index), .err_expected(err_expected),
        .err_actual(err_actual), .ovf(ovf), .ovf_index(ovf_index)
    );

    fib_stream_checker #(
        .DATA_WIDTH(DW), .MAX_TERMS(MT), .STRICT_SEED(1'b0)
    ) u_ns (
        .clk(clk), .resetn(resetn), .in_data(in_data), .in_en(in_en),
        .clear(clear), .busy(ns_busy), .term_count(ns_term_count),
        .done(ns_done), .err(ns_err), .err_index(ns_err_index),
        .err_expected(ns_err_expected), .err_actual(ns_err_actual),
        .ovf(ns_ovf), .ovf_index(ns_ovf_index)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state (strict-seed instance)
    int m_cnt, m_eidx, m_eexp, m_eact, m_oidx;
    bit m_busy, m_done, m_err, m_ovf, m_term;
    int hist[$];
    int fib[30];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_cnt = 0; m_eidx = 0; m_eexp = 0; m_eact = 0; m_oidx = 0;
        m_busy = 0; m_done = 0; m_err = 0; m_ovf = 0; m_term = 0;
        hist.delete();
    endtask

    task automatic m_edge(input bit en, input int d, input bit clr);
        int idx, full, ex;
        bit bad, wrap;
        m_done = 0;
        if (clr) begin
            m_reset();
            return;
        end
        if (en && !m_term) begin
            idx = hist.size();
            if (idx < 2) begin
                ex = 1; wrap = 0;
            end else begin
                full = hist[idx-1] + hist[idx-2];
                ex   = full % 256;
                wrap = full > 255;
            end
            bad = (d != ex);
            hist.push_back(d);
            m_cnt = idx + 1;
            if (bad) begin
                m_err = 1; m_eidx = idx; m_eexp = ex; m_eact = d; m_term = 1;
            end else begin
                if (wrap && !m_ovf) begin
                    m_ovf = 1; m_oidx = idx;
                end
                if (m_cnt == MT) begin
                    m_done = 1; m_term = 1;
                end
            end
        end
        m_busy = !m_term;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ".term_count"}, 32'(term_count), m_cnt);
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".err"}, 32'(err), 32'(m_err));
        chk({tag, ".err_index"}, 32'(err_index), m_eidx);
        chk({tag, ".err_expected"}, 32'(err_expected), m_eexp);
        chk({tag, ".err_actual"}, 32'(err_actual), m_eact);
        chk({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
        chk({tag, ".ovf_index"}, 32'(ovf_index), m_oidx);
    endtask

    task automatic cyc(input bit en, input int d, input bit clr,
                       input string tag);
        @(negedge clk);
        in_en   = en;
        in_data = DW'(d);
        clear   = clr;
        @(posedge clk);
        m_edge(en, d & 255, clr);
        #1;
        check_all(tag);
    endtask

    initial begin
        int bad_at, k, v;
        fib[0] = 1;
        fib[1] = 1;
        for (int i = 2; i < 30; i++) fib[i] = (fib[i-1] + fib[i-2]) % 256;
        m_reset();

        // reset state
        #2;
        check_all("reset");
        @(negedge clk);
        resetn = 1'b1;
        cyc(0, 0, 0, "idle");

        // plain run without wrap, then the first wrapped terms
        for (int i = 0; i < 13; i++) cyc(1, fib[i], 0, "run13");
        chk("run13.count_const", 32'(term_count), 13);
        cyc(1, 121, 0, "wrap1");
        cyc(1, 98, 0, "wrap2");
        chk("wrap.ovf_index_const", 32'(ovf_index), 13);

        // mismatch then ignored samples
        cyc(0, 0, 1, "clr1");
        cyc(1, 1, 0, "mm"); cyc(1, 1, 0, "mm"); cyc(1, 2, 0, "mm");
        cyc(1, 3, 0, "mm"); cyc(1, 6, 0, "mm");
        chk("mm.err_expected_const", 32'(err_expected), 5);
        for (int i = 0; i < 3; i++) cyc(1, $urandom_range(0, 255), 0, "mm_hold");

        // full run with random gaps to completion
        cyc(0, 0, 1, "clr2");
        k = 0;
        while (k < MT) begin
            if ($urandom_range(0, 2) == 0) begin
                cyc(0, $urandom_range(0, 255), 0, "gap");
            end else begin
                cyc(1, fib[k], 0, "full");
                k++;
            end
        end
        chk("full.done_const", 32'(done), 1);
        cyc(0, 0, 0, "done_drop");
        cyc(1, fib[MT], 0, "done_hold");

        // strict seed error vs. free seeds
        cyc(0, 0, 1, "clr3");
        cyc(1, 2, 0, "seed"); cyc(1, 3, 0, "seed");
        cyc(1, 5, 0, "seed"); cyc(1, 8, 0, "seed");
        chk("ns.err", 32'(ns_err), 0);
        chk("ns.term_count", 32'(ns_term_count), 4);
        chk("ns.busy", 32'(ns_busy), 1);
        chk("ns.ovf", 32'(ns_ovf), 0);

        // asynchronous reset between edges
        cyc(0, 0, 1, "clr4");
        for (int i = 0; i < 4; i++) cyc(1, fib[i], 0, "pre_rst");
        #2;
        resetn = 1'b0;
        #1;
        m_reset();
        check_all("async_rst");
        @(negedge clk);
        in_en = 1'b0;
        @(negedge clk);
        resetn = 1'b1;

        // clear wins over a simultaneous sample
        cyc(1, 1, 0, "pre_clr");
        cyc(1, 1, 1, "clr_en");
        cyc(1, 1, 0, "post_clr");

        // randomized runs with an optional corrupted term
        for (int r = 0; r < 8; r++) begin
            cyc(0, 0, 1, "rclr");
            bad_at = $urandom_range(0, 26);
            k = 0;
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    cyc(0, $urandom_range(0, 255), 0, "rgap");
                end else begin
                    v = fib[k % 30];
                    if (k == bad_at) v = v ^ $urandom_range(1, 255);
                    cyc(1, v, 0, "rand");
                    k++;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fib_stream_checker.md
Name: fib_stream_checker

Overview:
- Downstream consumer of the Fibonacci sequence generator.
- Samples the generator's output word on every enabled cycle and checks that each term equals the sum of the previous two, modulo 2^DATA_WIDTH.
- Records the first mismatch, records the first arithmetic overflow (wrap), counts terms, and signals completion after a programmed number of terms.
- Used as an on-chip self-check and as a bench monitor for the generator.

Parameters:
- DATA_WIDTH, 32, width of the sampled sequence word; must match the generator.
- MAX_TERMS, 64, number of accepted samples after which checking completes; must be ≥ 3.
- STRICT_SEED, 1, when 1 the first two samples must equal 1 and 1; when 0 they are taken as arbitrary seeds.
- CNT_W, $clog2(MAX_TERMS+1), width of the term counter and index outputs.

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- in_data  input  DATA_WIDTH  sequence term from the generator.
- in_en  input  1  in_data is a valid term this cycle.
- clear  input  1  synchronous restart of the checker.
- busy  output  1  checker is accepting samples (state SEED0, SEED1 or CHECK).
- term_count  output  CNT_W  number of samples accepted since reset/clear.
- done  output  1  one-cycle pulse when the MAX_TERMS-th sample is accepted.
- err  output  1  sticky mismatch flag.
- err_index  output  CNT_W  0-based index of the first mismatching sample.
- err_expected  output  DATA_WIDTH  expected value at the first mismatch.
- err_actual  output  DATA_WIDTH  received value at the first mismatch.
- ovf  output  1  sticky flag: a correct term required a carry out of DATA_WIDTH bits.
- ovf_index  output  CNT_W  0-based index of the first overflowing term.

Behaviour:
- Reset and clock: one clock, clk. Reset is asynchronous and active-low on resetn.
- Reset values: while resetn is low, all outputs are 0 and state is SEED0. Internal prev/prev2 registers are 0.
- Accepted sample: a sample is accepted when in_en = 1, clear = 0 and state ∈ {SEED0, SEED1, CHECK}. Cycles with in_en = 0 change nothing.
- Output timing: all outputs are registered and reflect an accepted sample on the cycle after it is sampled (1-cycle latency).
- State SEED0: on accept, prev ← in_data, term_count ← 1, go to SEED1.
  - If STRICT_SEED = 1 and in_data ≠ 1: mismatch with expected = 1.
- State SEED1: on accept, prev2 ← prev, prev ← in_data, term_count ← 2, go to CHECK.
  - If STRICT_SEED = 1 and in_data ≠ 1: mismatch with expected = 1.
- State CHECK: sum = prev + prev2 computed at DATA_WIDTH+1 bits; expected = sum[DATA_WIDTH-1:0]. On accept, term_count increments and prev2/prev shift.
  - If in_data ≠ expected: mismatch.
  - Else if sum[DATA_WIDTH] = 1 and ovf = 0: ovf ← 1, ovf_index ← current index (term_count before the increment).
- Mismatch (any state): err ← 1; err_index/err_expected/err_actual captured; term_count still increments to include the bad sample; go to ERROR. Only the first mismatch is ever captured.
- Completion: when an accept brings term_count to MAX_TERMS without a mismatch, done pulses for exactly one cycle and the state goes to DONE.
  - A mismatch on the MAX_TERMS-th sample goes to ERROR; done does not pulse.
- ERROR and DONE: terminal states. busy = 0, no samples accepted, all outputs hold until clear or reset.
- Clear: clear = 1 forces state to SEED0 and zeroes all outputs and internal registers on the next edge. clear has priority over a simultaneous in_en, and that sample is discarded.
- Reset mid-stream: asynchronous reset zeroes all outputs immediately (no clock needed). Checking restarts at SEED0 after resetn deasserts.
- Wrap-around: a term that wrapped is correct if it matches mod 2^DATA_WIDTH; wrap alone never sets err. The term counter never exceeds MAX_TERMS.

Test Plan:
All scenarios use DATA_WIDTH=8, MAX_TERMS=20, STRICT_SEED=1 unless noted.
- Reset, then feed 1,1,2,3,5,8,13,21,34,55,89,144,233 continuously -> term_count=13, busy=1, err=0, ovf=0.
- Continue with 121 (377 mod 256), then 98 (354 mod 256) -> ovf=1, ovf_index=13, err=0, term_count=15.
- After clear, feed 1,1,2,3,6 -> err=1, err_index=4, err_expected=5, err_actual=6, term_count=5, busy=0; further in_en pulses leave all outputs unchanged.
- Feed the 20 correct wrapped terms with random in_en gaps -> done high for exactly one cycle, one cycle after the 20th accept; term_count=20, busy=0; gaps cause no change.
- STRICT_SEED=1, first sample 2 -> err=1, err_index=0, err_expected=1, err_actual=2. With STRICT_SEED=0, seeds 2,3 followed by 5,8 -> err=0.
- Assert resetn low asynchronously between edges mid-CHECK -> all outputs 0 before the next clk edge. Separately, clear and in_en high in the same cycle -> term_count=0, sample discarded.
